// File: rtl/rand_range_sampler.sv
// Rejection sampler behind an LFSR: keeps words below LIMIT, buffers them in a
// 2-entry FIFO on a valid/ready stream, counts rejections and flags stalls.
module rand_range_sampler #(
  parameter int W         = 4,
  parameter int LIMIT     = 6,
  parameter int MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic [W-1:0] rnd_in,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [15:0]  rej_cnt,
  output logic         stall_err
);

  typedef enum logic [1:0] {IDLE, RUN, ERR} state_t;

  // Compared in W+1 bits so that LIMIT = 2**W accepts every word.
  localparam logic [W:0] LIM     = (W+1)'(LIMIT);
  localparam logic [7:0] TRY_MAX = 8'(MAX_TRIES);

  state_t       state;
  state_t       state_nxt;
  logic         sample_on;
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic [1:0]   count;
  logic [7:0]   try_cnt;
  logic         pop;
  logic         can_take;
  logic         eval;
  logic         accept;
  logic         push;
  logic         reject;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign out_valid = (count != 2'd0);
  assign out_data  = mem[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign can_take  = (count < 2'd2) | pop;
  assign eval      = sample_on & can_take;
  assign accept    = ({1'b0, rnd_in} < LIM);
  assign push      = eval & accept;
  assign reject    = eval & ~accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (en) state_nxt = RUN;
      RUN: begin
        if (!en)                                     state_nxt = IDLE;
        else if (reject && try_cnt == TRY_MAX - 8'd1) state_nxt = ERR;
      end
      ERR:  if (!en) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Sampling stops as soon as en drops, even before the state leaves RUN.
  always_comb begin
    sample_on = 1'b0;
    stall_err = 1'b0;
    case (state)
      RUN:     sample_on = en;
      ERR:     stall_err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      try_cnt <= 8'd0;
      rej_cnt <= 16'd0;
    end else begin
      if (state == ERR && !en) try_cnt <= 8'd0;
      else if (push)           try_cnt <= 8'd0;
      else if (reject)         try_cnt <= try_cnt + 8'd1;
      if (reject) rej_cnt <= sat_inc16(rej_cnt);
    end
  end

  // FIFO storage is cleared too so that out_data reads 0 after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= rnd_in;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rand_range_sampler.sv
// Directed bench for rand_range_sampler: stream order, stall/recovery, back-pressure,
// async reset, full-range LIMIT and rej_cnt saturation across four configurations.
module tb_rand_range_sampler;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en_a = 1'b0, en_b = 1'b0, en_c = 1'b0, en_d = 1'b0;
  logic [3:0] rnd = 4'd0;
  logic       ready = 1'b0;

  logic [3:0]  d_a, d_b, d_c, d_d;
  logic        v_a, v_b, v_c, v_d;
  logic [15:0] rej_a, rej_b, rej_c, rej_d;
  logic        st_a, st_b, st_c, st_d;

  int checks = 0;
  int errors = 0;
  logic [3:0] got [$];
  logic [3:0] seq  [7] = '{4'd1, 4'd8, 4'd12, 4'd6, 4'd11, 4'd5, 4'd2};
  logic [3:0] exp1 [6] = '{4'd1, 4'd5, 4'd2, 4'd1, 4'd5, 4'd2};
  logic [3:0] exp3 [3] = '{4'd1, 4'd5, 4'd2};

  always #5 clk = ~clk;

  rand_range_sampler #(.W(4), .LIMIT(6), .MAX_TRIES(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .en(en_a), .rnd_in(rnd), .out_data(d_a),
    .out_valid(v_a), .out_ready(ready), .rej_cnt(rej_a), .stall_err(st_a));
  rand_range_sampler #(.W(4), .LIMIT(6), .MAX_TRIES(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .en(en_b), .rnd_in(rnd), .out_data(d_b),
    .out_valid(v_b), .out_ready(ready), .rej_cnt(rej_b), .stall_err(st_b));
  rand_range_sampler #(.W(4), .LIMIT(1), .MAX_TRIES(255)) dut_c (
    .clk(clk), .reset_n(reset_n), .en(en_c), .rnd_in(rnd), .out_data(d_c),
    .out_valid(v_c), .out_ready(ready), .rej_cnt(rej_c), .stall_err(st_c));
  rand_range_sampler #(.W(4), .LIMIT(16), .MAX_TRIES(8)) dut_d (
    .clk(clk), .reset_n(reset_n), .en(en_d), .rnd_in(rnd), .out_data(d_d),
    .out_valid(v_d), .out_ready(ready), .rej_cnt(rej_d), .stall_err(st_d));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  // Record dut_a handshakes while inputs are stable, then step one clock.
  task automatic tick();
    if (v_a && ready) got.push_back(d_a);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    got.delete();
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", v_a, 0);
    check("rst_data", d_a, 0);
    check("rst_rej", rej_a, 0);
    check("rst_stall", st_a, 0);
    do_reset();

    // Stream order with out_ready=1
    ready = 1'b1; en_a = 1'b1;
    tick();
    for (int i = 0; i < 14; i++) begin
      rnd = seq[i % 7];
      tick();
      if (i == 0) begin
        check("t1_lat_valid", v_a, 1);
        check("t1_lat_data", d_a, 1);
      end
    end
    en_a = 1'b0; rnd = 4'd0;
    tick();
    tick();
    check("t1_len", got.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < got.size()) check($sformatf("t1_word%0d", i), got[i], exp1[i]);
    check("t1_rej", rej_a, 8);
    check("t1_stall", st_a, 0);
    check("t1_drained", v_a, 0);

    // Stall after MAX_TRIES=4 consecutive rejects, recovery via en
    do_reset();
    ready = 1'b1; en_b = 1'b1;
    tick();
    rnd = 4'd1;  tick();
    check("t2_first", d_b, 1);
    rnd = 4'd8;  tick();
    rnd = 4'd12; tick();
    rnd = 4'd6;  tick();
    check("t2_stall_pre", st_b, 0);
    check("t2_rej3", rej_b, 3);
    rnd = 4'd11; tick();
    check("t2_stall", st_b, 1);
    check("t2_rej4", rej_b, 4);
    rnd = 4'd5;  tick();
    check("t2_no_push", v_b, 0);
    rnd = 4'd8;  tick();
    check("t2_rej_hold", rej_b, 4);
    en_b = 1'b0; tick();
    check("t2_clear", st_b, 0);
    en_b = 1'b1; tick();
    rnd = 4'd5;  tick();
    check("t2_resume_v", v_b, 1);
    check("t2_resume_d", d_b, 5);
    rnd = 4'd8;  tick();
    rnd = 4'd12; tick();
    rnd = 4'd6;  tick();
    check("t2_retry_ok", st_b, 0);
    rnd = 4'd11; tick();
    check("t2_restall", st_b, 1);
    check("t2_rej8", rej_b, 8);

    // Back-pressure: FIFO full, then pop and push in the same edge
    do_reset();
    ready = 1'b0; en_a = 1'b1;
    tick();
    for (int i = 0; i < 20; i++) begin
      rnd = seq[i % 7];
      tick();
    end
    check("t3_hold_v", v_a, 1);
    check("t3_hold_d", d_a, 1);
    check("t3_rej", rej_a, 4);
    ready = 1'b1; rnd = 4'd2; tick();
    check("t4_pp_v", v_a, 1);
    check("t4_pp_d", d_a, 5);
    rnd = 4'd12; tick();
    check("t4_next_d", d_a, 2);
    check("t4_rej", rej_a, 5);
    rnd = 4'd8; tick();
    check("t4_empty", v_a, 0);
    check("t3_len", got.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < got.size()) check($sformatf("t3_word%0d", i), got[i], exp3[i]);

    // Asynchronous reset mid-stream
    do_reset();
    ready = 1'b0; en_a = 1'b1; en_b = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      rnd = seq[i];
      tick();
    end
    check("t5_pre_v", v_a, 1);
    check("t5_pre_rej", rej_a, 4);
    check("t5_pre_stall", st_b, 1);
    reset_n = 1'b0;
    #2;
    check("t5_v", v_a, 0);
    check("t5_d", d_a, 0);
    check("t5_rej", rej_a, 0);
    check("t5_stall", st_b, 0);
    en_a = 1'b0; en_b = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    rnd = 4'd3;
    tick();
    tick();
    check("t5_idle", v_a, 0);
    en_a = 1'b1; tick();
    tick();
    check("t5_run_v", v_a, 1);
    check("t5_run_d", d_a, 3);

    // LIMIT = 2**W accepts every word
    do_reset();
    ready = 1'b1; en_d = 1'b1;
    tick();
    rnd = 4'd15; tick();
    check("t6_d15", d_d, 15);
    rnd = 4'd9;  tick();
    check("t6_d9", d_d, 9);
    rnd = 4'd8;  tick();
    check("t6_d8", d_d, 8);
    check("t6_rej", rej_d, 0);

    // rej_cnt saturation: 257 stall periods of 255 rejects each
    do_reset();
    ready = 1'b1; rnd = 4'd5; en_c = 1'b1;
    tick();
    for (int p = 0; p < 257; p++) begin
      for (int k = 0; k < 300 && !st_c; k++) tick();
      if (!st_c) begin
        check("t6_stall_wait", st_c, 1);
        break;
      end
      if (p == 0) check("t6_rej255", rej_c, 255);
      en_c = 1'b0; tick();
      en_c = 1'b1; tick();
    end
    check("t6_sat", rej_c, 16'hFFFF);
    for (int k = 0; k < 20; k++) tick();
    check("t6_sat_hold", rej_c, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
